// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pkg
// Purpose  : Shared operation encodings and widths for the execute stage,
//            plus the divider state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ex_stage_pkg;

    localparam int ALUSelWidth  = 3;
    localparam int ALUOpWidth   = 8;
    localparam int RegWidth     = 32;
    localparam int RegAddrWidth = 5;

    // Operation classes
    localparam logic [ALUSelWidth-1:0] ALU_SEL_NOP   = 3'd0;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_LOGIC = 3'd1;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_SHIFT = 3'd2;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_ARITH = 3'd3;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_DIV   = 3'd4;
    localparam logic [ALUSelWidth-1:0] ALU_SEL_MUL   = 3'd5;

    // Operation codes
    localparam logic [ALUOpWidth-1:0] ALU_NOP   = 8'h00;
    localparam logic [ALUOpWidth-1:0] ALU_AND   = 8'h01;
    localparam logic [ALUOpWidth-1:0] ALU_OR    = 8'h02;
    localparam logic [ALUOpWidth-1:0] ALU_XOR   = 8'h03;
    localparam logic [ALUOpWidth-1:0] ALU_NOR   = 8'h04;
    localparam logic [ALUOpWidth-1:0] ALU_SLL   = 8'h05;
    localparam logic [ALUOpWidth-1:0] ALU_SRL   = 8'h06;
    localparam logic [ALUOpWidth-1:0] ALU_SRA   = 8'h07;
    localparam logic [ALUOpWidth-1:0] ALU_ADD   = 8'h08;
    localparam logic [ALUOpWidth-1:0] ALU_SUB   = 8'h09;
    localparam logic [ALUOpWidth-1:0] ALU_SLT   = 8'h0A;
    localparam logic [ALUOpWidth-1:0] ALU_SLTU  = 8'h0B;
    localparam logic [ALUOpWidth-1:0] ALU_DIV   = 8'h0C;
    localparam logic [ALUOpWidth-1:0] ALU_DIVU  = 8'h0D;
    localparam logic [ALUOpWidth-1:0] ALU_MOD   = 8'h0E;
    localparam logic [ALUOpWidth-1:0] ALU_MODU  = 8'h0F;
    localparam logic [ALUOpWidth-1:0] ALU_MUL   = 8'h10;
    localparam logic [ALUOpWidth-1:0] ALU_MULH  = 8'h11;
    localparam logic [ALUOpWidth-1:0] ALU_MULHU = 8'h12;

    // Iterative divider states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_div_iter  (the div_iter sub-module of ex_stage)
// Purpose  : Radix-2 restoring divider, one quotient bit per cycle, with
//            sign correction of quotient and remainder.
// Ports    : clk, rst (async, active-low)
//            start_i       divide op present in EX
//            signed_op_i   treat operands as two's complement
//            a_i, b_i      dividend, divisor
//            pause_hold_i  keep the result in DONE
//            abort_i       non-divide op in EX (flush)
//            busy_o, done_o, quotient_o, remainder_o
// Revision : 1.0  initial release
// ============================================================================
module ex_stage_div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_op_i,
    input  logic [RegWidth-1:0] a_i,
    input  logic [RegWidth-1:0] b_i,
    input  logic                pause_hold_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [RegWidth-1:0] quotient_o,
    output logic [RegWidth-1:0] remainder_o
);

    localparam int                CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RegWidth-1:0] quo_q, quo_d;   // dividend shifts out, quotient shifts in
    logic [RegWidth-1:0] rem_q, rem_d;
    logic [RegWidth-1:0] dvs_q, dvs_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;

    logic                w_a_neg, w_b_neg;
    logic [RegWidth-1:0] w_a_mag, w_b_mag;
    logic [RegWidth:0]   w_shift, w_diff;
    logic                w_fits;

    assign w_a_neg = signed_op_i & a_i[RegWidth-1];
    assign w_b_neg = signed_op_i & b_i[RegWidth-1];
    assign w_a_mag = w_a_neg ? (RegWidth'(0) - a_i) : a_i;
    assign w_b_mag = w_b_neg ? (RegWidth'(0) - b_i) : b_i;

    // Trial subtraction on the partial remainder extended by the next dividend bit
    assign w_shift = {rem_q, quo_q[RegWidth-1]};
    assign w_diff  = w_shift - {1'b0, dvs_q};
    assign w_fits  = ~w_diff[RegWidth];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    cnt_d = '0;
                    if (b_i == '0) begin
                        // Divide by zero: all-ones quotient, raw dividend as remainder
                        quo_d   = '1;
                        rem_d   = a_i;
                        dvs_d   = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DIV_DONE;
                    end else begin
                        quo_d   = w_a_mag;
                        rem_d   = '0;
                        dvs_d   = w_b_mag;
                        qneg_d  = w_a_neg ^ w_b_neg;
                        rneg_d  = w_a_neg;
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = w_fits ? w_diff[RegWidth-1:0] : w_shift[RegWidth-1:0];
                    quo_d = {quo_q[RegWidth-2:0], w_fits};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DIV_DONE: begin
                if (!pause_hold_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign busy_o      = (state_q == DIV_BUSY);
    assign done_o      = (state_q == DIV_DONE);
    assign quotient_o  = qneg_q ? (RegWidth'(0) - quo_q) : quo_q;
    assign remainder_o = rneg_q ? (RegWidth'(0) - rem_q) : rem_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage: combinational ALU (logic/shift/arith), iterative
//            divider with pipeline pause request, optional multiplier.
// Config   : EX_MUL_EN - when defined, compiles in the single-cycle Mul class;
//            otherwise Mul ops return 0.
// Ports    : clk, rst (async, active-low), pause[5:0] (bit 3 = EX/MEM hold)
//            ex_alusel, ex_aluop, ex_reg1, ex_reg2, ex_reg_write_addr/en
//            mem_reg_write_data/addr/en, pause_request
// Revision : 1.0  initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              pause,
    input  logic [ALUSelWidth-1:0]  ex_alusel,
    input  logic [ALUOpWidth-1:0]   ex_aluop,
    input  logic [RegWidth-1:0]     ex_reg1,
    input  logic [RegWidth-1:0]     ex_reg2,
    input  logic [RegAddrWidth-1:0] ex_reg_write_addr,
    input  logic                    ex_reg_write_en,
    output logic [RegWidth-1:0]     mem_reg_write_data,
    output logic [RegAddrWidth-1:0] mem_reg_write_addr,
    output logic                    mem_reg_write_en,
    output logic                    pause_request
);

    logic                w_div_op, w_div_signed, w_div_rem;
    logic                w_div_busy, w_div_done;
    logic [RegWidth-1:0] w_quotient, w_remainder;
    logic [4:0]          w_shamt;
    logic [RegWidth-1:0] w_sra;
    logic                w_slt, w_sltu;
    logic [RegWidth-1:0] w_result;
    logic                w_pause_unused;

    // Only the EX/MEM hold bit matters to this stage
    assign w_pause_unused = ^{pause[5:4], pause[2:0], w_div_busy};

    always_comb begin
        w_div_op     = 1'b0;
        w_div_signed = 1'b0;
        w_div_rem    = 1'b0;
        if (ex_alusel == ALU_SEL_DIV) begin
            case (ex_aluop)
                ALU_DIV:  begin w_div_op = 1'b1; w_div_signed = 1'b1; end
                ALU_MOD:  begin w_div_op = 1'b1; w_div_signed = 1'b1; w_div_rem = 1'b1; end
                ALU_DIVU: begin w_div_op = 1'b1; end
                ALU_MODU: begin w_div_op = 1'b1; w_div_rem = 1'b1; end
                default:  ;
            endcase
        end
    end

    ex_stage_div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk          (clk),
        .rst          (rst),
        .start_i      (w_div_op),
        .signed_op_i  (w_div_signed),
        .a_i          (ex_reg1),
        .b_i          (ex_reg2),
        .pause_hold_i (pause[3]),
        .abort_i      (~w_div_op),
        .busy_o       (w_div_busy),
        .done_o       (w_div_done),
        .quotient_o   (w_quotient),
        .remainder_o  (w_remainder)
    );

    assign pause_request = w_div_op & ~w_div_done;

    assign w_shamt = ex_reg2[4:0];
    assign w_sra   = $signed(ex_reg1) >>> w_shamt;
    assign w_slt   = $signed(ex_reg1) < $signed(ex_reg2);
    assign w_sltu  = ex_reg1 < ex_reg2;

`ifdef EX_MUL_EN
    logic [2*RegWidth-1:0] w_mul_s;
    logic [RegWidth-1:0]   w_mulhu;
    // Sign-extended operands give the signed product in the low 64 bits
    assign w_mul_s = {{RegWidth{ex_reg1[RegWidth-1]}}, ex_reg1}
                   * {{RegWidth{ex_reg2[RegWidth-1]}}, ex_reg2};
    assign w_mulhu = RegWidth'(({{RegWidth{1'b0}}, ex_reg1}
                   * {{RegWidth{1'b0}}, ex_reg2}) >> RegWidth);
`endif

    always_comb begin
        w_result = '0;
        case (ex_alusel)
            ALU_SEL_LOGIC: begin
                case (ex_aluop)
                    ALU_AND: w_result = ex_reg1 & ex_reg2;
                    ALU_OR:  w_result = ex_reg1 | ex_reg2;
                    ALU_XOR: w_result = ex_reg1 ^ ex_reg2;
                    ALU_NOR: w_result = ~(ex_reg1 | ex_reg2);
                    default: w_result = '0;
                endcase
            end
            ALU_SEL_SHIFT: begin
                case (ex_aluop)
                    ALU_SLL: w_result = ex_reg1 << w_shamt;
                    ALU_SRL: w_result = ex_reg1 >> w_shamt;
                    ALU_SRA: w_result = w_sra;
                    default: w_result = '0;
                endcase
            end
            ALU_SEL_ARITH: begin
                case (ex_aluop)
                    ALU_ADD:  w_result = ex_reg1 + ex_reg2;
                    ALU_SUB:  w_result = ex_reg1 - ex_reg2;
                    ALU_SLT:  w_result = {{(RegWidth-1){1'b0}}, w_slt};
                    ALU_SLTU: w_result = {{(RegWidth-1){1'b0}}, w_sltu};
                    default:  w_result = '0;
                endcase
            end
            ALU_SEL_DIV: begin
                if (w_div_op) begin
                    w_result = w_div_rem ? w_remainder : w_quotient;
                end
            end
`ifdef EX_MUL_EN
            ALU_SEL_MUL: begin
                case (ex_aluop)
                    ALU_MUL:   w_result = w_mul_s[RegWidth-1:0];
                    ALU_MULH:  w_result = w_mul_s[2*RegWidth-1:RegWidth];
                    ALU_MULHU: w_result = w_mulhu;
                    default:   w_result = '0;
                endcase
            end
`else
            ALU_SEL_MUL: w_result = '0;
`endif
            default: w_result = '0;
        endcase
    end

    assign mem_reg_write_data = w_result;
    assign mem_reg_write_addr = ex_reg_write_addr;
    assign mem_reg_write_en   = ex_reg_write_en;

endmodule
`default_nettype wire
